// File: rtl/spi_master_xfer.sv
// spi_master_xfer: single-clock SPI master (mode 0 style: sck idles low, slave samples mosi on
// sck rise, master samples miso on sck fall).
//
// Ports:
//   clock, resetn          system clock; synchronous active-low reset
//   req_valid/req_ready    request handshake; ready only while idle
//   req_data, req_len      TX word and bit count (0 or >WIDTH means WIDTH)
//   req_lsb_first          1: bit 0 first on the wire; 0: bit len-1 first
//   resp_valid, resp_data  one-cycle completion pulse; RX word held until the next pulse
//   busy                   high whenever not idle
//   sck, ss, mosi, miso    SPI wire signals (ss active low)
//
// All outputs come straight from registers.

module spi_master_xfer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIV   = 2,
  parameter int unsigned LENW  = 5
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_data,
  input  logic [LENW-1:0]  req_len,
  input  logic             req_lsb_first,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             busy,
  output logic             sck,
  output logic             ss,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);
  localparam logic [LENW-1:0] LenMax = LENW'(WIDTH);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StLow  = 3'd1;
  localparam logic [2:0] StHigh = 3'd2;
  localparam logic [2:0] StHold = 3'd3;
  localparam logic [2:0] StDone = 3'd4;  // the single resp_valid cycle, ss already high
  localparam logic [2:0] StGap  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [LENW-1:0]  bit_q, bit_d;
  logic [LENW-1:0]  len_q, len_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] tx_q, tx_d;
  logic [WIDTH-1:0] rx_q, rx_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic             resp_valid_q, resp_valid_d;
  logic             sck_q, sck_d;
  logic             ss_q, ss_d;
  logic             mosi_q, mosi_d;

  logic [LENW-1:0]  len_eff;
  logic [LENW-1:0]  bit_nxt;

  // Wire position k maps to data bit k (lsb first) or len-1-k (msb first).
  function automatic logic [LENW-1:0] bit_index(input logic            lsb,
                                                input logic [LENW-1:0] len,
                                                input logic [LENW-1:0] k);
    return lsb ? k : (len - LENW'(1) - k);
  endfunction

  function automatic logic tx_bit(input logic [WIDTH-1:0] data, input logic [LENW-1:0] idx);
    logic [WIDTH-1:0] shifted;
    shifted = data >> idx;
    return shifted[0];
  endfunction

  always_comb begin
    len_eff = ((req_len == '0) || (req_len > LenMax)) ? LenMax : req_len;
    bit_nxt = bit_q + LENW'(1);

    state_d      = state_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    len_d        = len_q;
    lsb_d        = lsb_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = 1'b0;
    sck_d        = sck_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = StLow;
          cnt_d   = '0;
          bit_d   = '0;
          len_d   = len_eff;
          lsb_d   = req_lsb_first;
          tx_d    = req_data;
          rx_d    = '0;
          ss_d    = 1'b0;
          sck_d   = 1'b0;
          mosi_d  = tx_bit(req_data, bit_index(req_lsb_first, len_eff, '0));
        end
      end
      StLow: begin
        if (cnt_q == CntLast) begin
          state_d = StHigh;
          cnt_d   = '0;
          sck_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHigh: begin
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          sck_d = 1'b0;
          // rx_q was cleared at accept, so OR-ing in each bit is enough.
          rx_d  = rx_q | (WIDTH'(miso) << bit_index(lsb_q, len_q, bit_q));
          bit_d = bit_nxt;
          if (bit_nxt < len_q) begin
            state_d = StLow;
            mosi_d  = tx_bit(tx_q, bit_index(lsb_q, len_q, bit_nxt));
          end else begin
            state_d = StHold;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StHold: begin
        if (cnt_q == CntLast) begin
          state_d      = StDone;
          cnt_d        = '0;
          ss_d         = 1'b1;
          mosi_d       = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = rx_q;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        state_d = StGap;
        cnt_d   = '0;
      end
      StGap: begin
        if (cnt_q == CntLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        ss_d    = 1'b1;
        sck_d   = 1'b0;
        mosi_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      bit_q        <= '0;
      len_q        <= '0;
      lsb_q        <= 1'b0;
      tx_q         <= '0;
      rx_q         <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      sck_q        <= 1'b0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      len_q        <= len_d;
      lsb_q        <= lsb_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;

endmodule

// File: doc/spi_master_xfer.md
Name: spi_master_xfer

Overview:
- Single-clock SPI master: the initiator end of the SPI link served by our SPI slave peripherals (e.g. the bit-reversal responder).
- Accepts a transfer request (TX word and bit count) over a valid/ready handshake and generates ss/sck/mosi.
- Samples miso and returns the RX word with a one-cycle response pulse.
- Sits between the SoC-side SPI controller logic and the perip SPI slaves; also serves as the bench driver for them.

Parameters:
- WIDTH, 16: maximum bits per transfer; width of TX/RX data.
- DIV, 2: sck half-period in clock cycles; legal range >= 1.
- LENW, 5: width of req_len; must be >= clog2(WIDTH+1).

Ports:
- clock  input  1  system clock; all logic on posedge.
- resetn  input  1  synchronous, active-low reset.
- req_valid  input  1  transfer request valid.
- req_ready  output  1  high only in IDLE.
- req_data  input  WIDTH  TX bits.
- req_len  input  LENW  bit count; 0 or >WIDTH is treated as WIDTH.
- req_lsb_first  input  1  1: bit0 first on the wire; 0: bit len-1 first.
- resp_valid  output  1  one-cycle pulse when the transfer completes.
- resp_data  output  WIDTH  received bits; held until the next resp_valid.
- busy  output  1  high in every state except IDLE.
- sck  output  1  SPI clock; idles low.
- ss  output  1  slave select, active low; idles high.
- mosi  output  1  master out; idles high.
- miso  input  1  slave out.

Behaviour:
- Reset: resetn=0 at a posedge puts the block in IDLE next cycle.
  - Reset values: ss=1, sck=0, mosi=1, req_ready=1, busy=0, resp_valid=0, resp_data=0, counters=0.
  - Reset mid-transfer aborts immediately with no resp_valid; it is legal at any time.
- All outputs are registered; none depends combinationally on inputs.
- States:
  - IDLE: accept on req_valid && req_ready. Latch data, effective length L, bit order; clear RX shift register; go to LOW.
  - LOW: ss=0, sck=0, mosi=current TX bit; lasts DIV cycles; then go to HIGH.
  - HIGH: sck=1 for DIV cycles.
    - In its last cycle, register miso into the RX bit slot and advance the bit index.
    - If bits sent < L: return to LOW and present the next TX bit on mosi at the high-to-low transition.
    - Otherwise go to HOLD.
  - HOLD: sck=0, ss=0, mosi unchanged, for DIV cycles; then ss=1, mosi=1, resp_valid=1 for one cycle, resp_data updated; go to GAP.
  - GAP: ss=1 for DIV cycles (minimum deselect time); then go to IDLE. req_ready is low throughout GAP.
- Wire timing:
  - mosi changes only while sck is low (ss fall or sck fall), so the slave samples it stably on sck rise.
  - miso is sampled at sck fall, i.e. a half-period after the slave updates it on sck rise.
- Latency: acceptance at cycle 0 gives ss=0 from cycle 1 and resp_valid in cycle 1+2*L*DIV+DIV.
  - Next acceptance is possible at cycle 2+2*L*DIV+2*DIV at earliest.
- Bit order:
  - lsb_first=1: k-th wire bit (k=0..L-1) is req_data[k]; k-th sampled bit goes to resp_data[k].
  - lsb_first=0: k-th wire bit is req_data[L-1-k]; k-th sampled bit goes to resp_data[L-1-k].
  - resp_data bits >= L are 0.
- Exactly L sck rising edges per transfer; sck never toggles while ss=1.
- req_valid while busy is ignored (req_ready=0); there is no queueing.

Test Plan:
- Reset check: hold resetn=0 for 3 cycles -> ss=1, sck=0, mosi=1, req_ready=1, resp_valid=0, resp_data=0.
- Loopback: miso tied to mosi, DIV=2, L=8, data=0xA5, lsb_first=1 -> 8 sck pulses of 4 cycles each; mosi sequence 1,0,1,0,0,1,0,1; resp_valid at cycle 35 after accept; resp_data=0x00A5.
- MSB-first loopback: L=12, data=0x0C3A, lsb_first=0 -> mosi sequence starts 1,1,0,0; resp_data=0x0C3A; bits 15:12=0.
- Length edges:
  - req_len=0 or req_len=20 -> 16 sck pulses.
  - req_len=1, DIV=1 -> 1 sck pulse; resp_valid at cycle 4.
  - Back-to-back requests -> ss high for at least DIV cycles between frames.
- Against the bit-reversal slave: DIV=1, L=15, data=0x00B4, lsb_first=1 -> resp_data=0x16FF.
  - Bits 6:0 read 1 (slave miso idle value); bit 7 = data bit 7; bits 14:8 = data bits 6..0.
- Abort: assert resetn=0 during the 5th HIGH phase -> next cycle ss=1, sck=0, no resp_valid; a new 8-bit loopback transfer then completes correctly.
